// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns a NUM_REGS x DATA_W register file and shares its
// single write port between NUM_REQ requesters with a req/ack handshake.
// Handshake: a requester raises req with wr_addr/wr_data and holds all three
// stable through the cycle its ack is high; gnt marks the WRITE cycle, ack
// pulses once when the write is committed, and an acked requester is masked
// for that ack cycle so it cannot be re-granted before it could drop req.
// Optional build macro: REGARB_FIXED_PRIO_EN selects fixed priority (lowest
// eligible index wins, no rr pointer); undefined gives round-robin.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_W-1:0]    wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    wr_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         busy,
  output logic [NUM_REGS*DATA_W-1:0]   reg_file_out,
  output logic                         o_dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t                r_state;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_ack;
  logic [IDX_W-1:0]      r_winner;
  logic [DATA_W-1:0]     r_regs [NUM_REGS];
`ifndef REGARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]      r_rr;
`endif

  logic [NUM_REQ-1:0]    w_eligible;
  logic                  w_found;
  logic [IDX_W-1:0]      w_winner;
  int                    w_idx;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [DATA_W-1:0]     w_sel_data;

  assign w_eligible = req & ~r_ack;

  // Pick the first eligible requester, scanning from the rr pointer (or from 0).
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef REGARB_FIXED_PRIO_EN
      w_idx = k;
`else
      w_idx = int'(r_rr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
`endif
      if (!w_found && w_eligible[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(w_idx);
      end
    end
  end

  // Route the granted requester's address and data to the write port.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == r_winner) begin
        w_sel_addr = wr_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Arbitration FSM plus the register file; reset discards any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_winner <= '0;
`ifndef REGARB_FIXED_PRIO_EN
      r_rr     <= '0;
`endif
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= '0;
          if (w_found) begin
            r_gnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
            r_winner <= w_winner;
            r_state  <= S_WRITE;
          end else begin
            r_gnt <= '0;
          end
        end
        S_WRITE: begin
          r_regs[w_sel_addr] <= w_sel_data;
          r_ack   <= r_gnt;
          r_gnt   <= '0;
`ifndef REGARB_FIXED_PRIO_EN
          if (r_winner == IDX_W'(NUM_REQ-1)) r_rr <= '0;
          else                               r_rr <= r_winner + 1'b1;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Flatten the register file, r0 in the low byte; no write bypass.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) reg_file_out[r*DATA_W +: DATA_W] = r_regs[r];
  end

  assign gnt         = r_gnt;
  assign ack         = r_ack;
  assign busy        = (r_state == S_WRITE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (default parameters).
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  gnt;
  logic [1:0]  ack;
  logic        busy;
  logic [63:0] reg_file_out;
  logic        o_dbg_state;

  int checks;
  int failures;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt), .ack(ack), .busy(busy), .reg_file_out(reg_file_out),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Driver helpers
  task automatic set_req0(input logic [2:0] a, input logic [7:0] d);
    wr_addr[2:0] = a;
    wr_data[7:0] = d;
  endtask

  task automatic set_req1(input logic [2:0] a, input logic [7:0] d);
    wr_addr[5:3]  = a;
    wr_data[15:8] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 2'b00;
    tick();
    tick();
    checks++;
    if (reg_file_out !== 64'h0 || gnt !== 2'b00 || ack !== 2'b00 || busy !== 1'b0 || o_dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL reset: regs=%h gnt=%b ack=%b busy=%b state=%b, want all zero",
               reg_file_out, gnt, ack, busy, o_dbg_state);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (reg_file_out !== 64'h0 || gnt !== 2'b00 || ack !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: regs=%h gnt=%b ack=%b busy=%b, want all zero",
               reg_file_out, gnt, ack, busy);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    set_req0(3'd3, 8'h2A);
    req = 2'b01;
    tick();
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1 || ack !== 2'b00 || reg_file_out !== 64'h0) begin
      failures++;
      $display("FAIL single_grant: gnt=%b busy=%b ack=%b regs=%h, want 01 1 00 0",
               gnt, busy, ack, reg_file_out);
    end
    tick();
    checks++;
    if (ack !== 2'b01 || gnt !== 2'b00 || busy !== 1'b0 || reg_file_out !== 64'h0000_0000_2A00_0000) begin
      failures++;
      $display("FAIL single_ack: ack=%b gnt=%b busy=%b regs=%h, want 01 00 0 r3=2A",
               ack, gnt, busy, reg_file_out);
    end
    req = 2'b00;
    tick();
    checks++;
    if (ack !== 2'b00 || gnt !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_after: ack=%b gnt=%b busy=%b, want 00 00 0", ack, gnt, busy);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt;
    do_reset();
    set_req0(3'd1, 8'd5);
    set_req1(3'd2, 8'd9);
    req = 2'b11;
    // Ack masking hands each ack cycle to the other requester: 0,1,0,1.
    for (int g = 0; g < 4; g++) begin
      exp_gnt = (g % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      checks++;
      if (gnt !== exp_gnt || busy !== 1'b1) begin
        failures++;
        $display("FAIL contention_gnt%0d: gnt=%b busy=%b, want %b 1", g, gnt, busy, exp_gnt);
      end
      tick();
      checks++;
      if (ack !== exp_gnt || gnt !== 2'b00) begin
        failures++;
        $display("FAIL contention_ack%0d: ack=%b gnt=%b, want %b 00", g, ack, gnt, exp_gnt);
      end
    end
    req = 2'b00;
    tick();
    checks++;
    if (reg_file_out !== 64'h0000_0000_0009_0500) begin
      failures++;
      $display("FAIL contention_regs: regs=%h, want r1=05 r2=09", reg_file_out);
    end
  endtask

  task automatic test_rr_pointer();
    do_reset();
    set_req0(3'd0, 8'h01);
    set_req1(3'd6, 8'h66);
    req = 2'b01;
    tick();
    tick();
    req = 2'b00;
    tick();
    // Both raised fresh with no ack pending; pointer now favours requester 1.
    req = 2'b11;
    tick();
    checks++;
`ifdef REGARB_FIXED_PRIO_EN
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL rr_pointer: gnt=%b, want 01", gnt);
    end
`else
    if (gnt !== 2'b10) begin
      failures++;
      $display("FAIL rr_pointer: gnt=%b, want 10", gnt);
    end
`endif
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_same_address();
    do_reset();
    set_req0(3'd4, 8'd7);
    set_req1(3'd4, 8'd11);
    req = 2'b11;
    tick();
    tick();
    checks++;
    if (ack !== 2'b01 || reg_file_out !== 64'h0000_0007_0000_0000) begin
      failures++;
      $display("FAIL same_addr_first: ack=%b regs=%h, want 01 r4=07", ack, reg_file_out);
    end
    req = 2'b10;
    tick();
    checks++;
    if (gnt !== 2'b10 || reg_file_out !== 64'h0000_0007_0000_0000) begin
      failures++;
      $display("FAIL same_addr_nobypass: gnt=%b regs=%h, want 10 r4=07", gnt, reg_file_out);
    end
    tick();
    checks++;
    if (ack !== 2'b10 || reg_file_out !== 64'h0000_000B_0000_0000) begin
      failures++;
      $display("FAIL same_addr_second: ack=%b regs=%h, want 10 r4=0B", ack, reg_file_out);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_req0(3'd5, 8'd99);
    req = 2'b01;
    tick();
    checks++;
    if (gnt !== 2'b01 || o_dbg_state !== 1'b1) begin
      failures++;
      $display("FAIL midrst_grant: gnt=%b state=%b, want 01 1", gnt, o_dbg_state);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (reg_file_out !== 64'h0 || ack !== 2'b00 || gnt !== 2'b00 || busy !== 1'b0 || o_dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL midrst_discard: regs=%h ack=%b gnt=%b busy=%b state=%b, want all zero",
               reg_file_out, ack, gnt, busy, o_dbg_state);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 2'b01 || ack !== 2'b00) begin
      failures++;
      $display("FAIL midrst_regrant: gnt=%b ack=%b, want 01 00", gnt, ack);
    end
    tick();
    checks++;
    if (ack !== 2'b01 || reg_file_out !== 64'h0000_6300_0000_0000) begin
      failures++;
      $display("FAIL midrst_write: ack=%b regs=%h, want 01 r5=63", ack, reg_file_out);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_idle_stability();
    do_reset();
    set_req0(3'd7, 8'h5C);
    req = 2'b01;
    tick();
    tick();
    req = 2'b00;
    for (int i = 0; i < 20; i++) begin
      wr_addr = 6'(i * 5);
      wr_data = 16'(i * 16'h1357);
      tick();
      checks++;
      if (gnt !== 2'b00 || ack !== 2'b00 || reg_file_out !== 64'h5C00_0000_0000_0000) begin
        failures++;
        $display("FAIL idle_cycle%0d: gnt=%b ack=%b regs=%h, want 00 00 r7=5C",
                 i, gnt, ack, reg_file_out);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 2'b00;
    wr_addr  = '0;
    wr_data  = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_rr_pointer();
    test_same_address();
    test_reset_mid_op();
    test_idle_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
